// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and constants for the shared-ALU arbiter and its ALU datapath.
// Holds the ALU operand/result types, the function codes and the valid-code check.
package alu_share_arbiter_pkg;

    localparam int ALU_ARB_MAX_REQ = 4;
    localparam int ALU_FUN_W       = 4;

    localparam logic [ALU_FUN_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_FUN_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_FUN_W-1:0] ALU_AND  = 4'd2;
    localparam logic [ALU_FUN_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_FUN_W-1:0] ALU_XOR  = 4'd4;
    localparam logic [ALU_FUN_W-1:0] ALU_SLL  = 4'd5;
    localparam logic [ALU_FUN_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_FUN_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_FUN_W-1:0] ALU_SLT  = 4'd8;
    localparam logic [ALU_FUN_W-1:0] ALU_SLTU = 4'd9;

    typedef struct packed {
        logic [ALU_FUN_W-1:0] fun;
        logic [31:0]          op1;
        logic [31:0]          op2;
    } alu_in_t;

    typedef struct packed {
        logic [31:0] data;
    } alu_out_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } alu_rsp_t;

    function automatic logic alu_fun_valid(input logic [ALU_FUN_W-1:0] fun);
        case (fun)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
            ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit integer ALU; undefined function codes produce zero.
module alu
    import alu_share_arbiter_pkg::*;
(
    input  alu_in_t  alu_in,
    output alu_out_t alu_out
);

    always_comb begin
        alu_out.data = '0;
        case (alu_in.fun)
            ALU_ADD:  alu_out.data = alu_in.op1 + alu_in.op2;
            ALU_SUB:  alu_out.data = alu_in.op1 - alu_in.op2;
            ALU_AND:  alu_out.data = alu_in.op1 & alu_in.op2;
            ALU_OR:   alu_out.data = alu_in.op1 | alu_in.op2;
            ALU_XOR:  alu_out.data = alu_in.op1 ^ alu_in.op2;
            ALU_SLL:  alu_out.data = alu_in.op1 << alu_in.op2[4:0];
            ALU_SRL:  alu_out.data = alu_in.op1 >> alu_in.op2[4:0];
            ALU_SRA:  alu_out.data = $unsigned($signed(alu_in.op1) >>> alu_in.op2[4:0]);
            ALU_SLT:  alu_out.data = {31'b0, $signed(alu_in.op1) < $signed(alu_in.op2)};
            ALU_SLTU: alu_out.data = {31'b0, alu_in.op1 < alu_in.op2};
            default:  alu_out.data = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request scanning from ptr upward, wrapping.
// Reusable by any shared unit that keeps its own pointer register.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    int               idx;
    logic [IDX_W-1:0] sel;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        sel         = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            sel = IDX_W'(idx);
            if (!grant_valid && req[sel]) begin
                grant_valid = 1'b1;
                grant[sel]  = 1'b1;
                grant_idx   = sel;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// One ALU shared by NUM_REQ requesters through a round-robin arbiter, with a
// single registered response slot under valid/ready backpressure.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  alu_in_t [NUM_REQ-1:0] req_alu_in,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err
);

    if (NUM_REQ < 2 || NUM_REQ > ALU_ARB_MAX_REQ) begin : g_bad_num_req
        $error("alu_share_arbiter: NUM_REQ out of range");
    end

    // Handshakes: a beat moves on a posedge where valid && ready. Producers hold
    // payload while valid && !ready; req_ready may follow req_valid combinationally,
    // so req_valid must never be derived from req_ready.
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    ptr_next;
    logic [ID_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic               out_free;
    alu_in_t            alu_in;
    alu_out_t           alu_out;
    alu_rsp_t           rsp_q;

    assign out_free  = !rsp_valid || rsp_ready;
    assign arb_req   = out_free ? req_valid : '0;
    assign req_ready = rst_n ? grant : '0;
    assign ptr_next  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    // With no grant, requester 0 feeds the ALU and the result is discarded.
    assign alu_in = grant_valid ? req_alu_in[grant_idx] : req_alu_in[0];

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_rr_arbiter (
        .req         (arb_req),
        .ptr         (ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    alu u_alu (
        .alu_in  (alu_in),
        .alu_out (alu_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_q     <= '0;
            ptr       <= '0;
        end else if (grant_valid) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= grant_idx;
            rsp_q.err  <= !alu_fun_valid(alu_in.fun);
            rsp_q.data <= alu_fun_valid(alu_in.fun) ? alu_out.data : '0;
            ptr        <= ptr_next;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign rsp_data = rsp_q.data;
    assign rsp_err  = rsp_q.err;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus a random
// back-to-back run, with responses checked against an expected-result queue.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;
    localparam int W       = ID_W + 33;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    alu_in_t [NUM_REQ-1:0] req_alu_in = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_data;
    logic                  rsp_err;

    int         errors = 0;
    int         checks = 0;
    logic [W-1:0] exp_q[$];
    int         m_ptr = 0;
    logic       m_valid = 1'b0;

    alu_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_alu_in (req_alu_in),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic alu_in_t mk(input logic [3:0] fun, input logic [31:0] a, input logic [31:0] b);
        alu_in_t t;
        t.fun = fun;
        t.op1 = a;
        t.op2 = b;
        return t;
    endfunction

    // Reference result {data, err}
    function automatic logic [32:0] ref_alu(input alu_in_t a);
        logic [31:0] d;
        logic        e;
        logic signed [31:0] s1;
        d  = 32'd0;
        e  = 1'b0;
        s1 = a.op1;
        case (a.fun)
            ALU_ADD:  d = a.op1 + a.op2;
            ALU_SUB:  d = a.op1 + (~a.op2) + 32'd1;
            ALU_AND:  d = a.op1 & a.op2;
            ALU_OR:   d = a.op1 | a.op2;
            ALU_XOR:  d = a.op1 ^ a.op2;
            ALU_SLL:  d = a.op1 << a.op2[4:0];
            ALU_SRL:  d = a.op1 >> a.op2[4:0];
            ALU_SRA:  d = s1 >>> a.op2[4:0];
            ALU_SLT:  d = (s1 < $signed(a.op2)) ? 32'd1 : 32'd0;
            ALU_SLTU: d = (a.op1 < a.op2) ? 32'd1 : 32'd0;
            default:  e = 1'b1;
        endcase
        return {d, e};
    endfunction

    function automatic int exp_idx(input logic [NUM_REQ-1:0] v, input int p, input logic free);
        int i;
        if (!free) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            i = (p + k) % NUM_REQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] mask_of(input int idx);
        logic [NUM_REQ-1:0] m;
        m = '0;
        if (idx >= 0) m[idx] = 1'b1;
        return m;
    endfunction

    // Advances the reference model by one clock edge and queues any expected response.
    task automatic model_step();
        int          g;
        logic [32:0] r;
        g = exp_idx(req_valid, m_ptr, !m_valid || rsp_ready);
        if (g >= 0) begin
            r = ref_alu(req_alu_in[g]);
            exp_q.push_back({ID_W'(g), r});
            m_ptr   = (g + 1) % NUM_REQ;
            m_valid = 1'b1;
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Response scoreboard: every consumed response must match the queue head.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_n && rsp_valid && rsp_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d data=%h err=%b, required no response",
                         rsp_id, rsp_data, rsp_err);
            end else begin
                e = exp_q.pop_front();
                if ({rsp_id, rsp_data, rsp_err} !== e) begin
                    errors++;
                    $display("FAIL rsp_scoreboard: got id=%0d data=%h err=%b, required id=%0d data=%h err=%b",
                             rsp_id, rsp_data, rsp_err, e[W-1 -: ID_W], e[32:1], e[0]);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n         = 1'b0;
        req_valid     = 2'b11;
        rsp_ready     = 1'b1;
        req_alu_in[0] = mk(ALU_ADD, 32'd1, 32'd2);
        req_alu_in[1] = mk(ALU_OR, 32'd8, 32'd4);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 2'b00 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: req_ready=%b rsp_valid=%b, required 00 and 0", req_ready, rsp_valid);
            end
        end
        checks++;
        if ({rsp_id, rsp_data, rsp_err} !== '0) begin
            errors++;
            $display("FAIL reset_values: id=%0d data=%h err=%b, required all zero", rsp_id, rsp_data, rsp_err);
        end
        next_cycle();
        rst_n   = 1'b1;
        m_ptr   = 0;
        m_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_grant: req_ready=%b, required 01", req_ready);
        end
        model_step();
    endtask

    task automatic test_single_request();
        next_cycle();
        req_valid     = 2'b10;
        req_alu_in[1] = mk(ALU_ADD, 32'd5, 32'd7);
        rsp_ready     = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL single_grant: req_ready=%b, required 10", req_ready);
        end
        model_step();
        next_cycle();
        req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'd12 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: valid=%b id=%0d data=%h err=%b, required 1 1 0000000c 0",
                     rsp_valid, rsp_id, rsp_data, rsp_err);
        end
        model_step();
    endtask

    task automatic test_contention();
        logic [NUM_REQ-1:0] exp_mask;
        logic [31:0]        exp_data;
        next_cycle();
        req_valid     = 2'b11;
        req_alu_in[0] = mk(ALU_SUB, 32'd10, 32'd3);
        req_alu_in[1] = mk(ALU_XOR, 32'h0000_00F0, 32'h0000_000F);
        rsp_ready     = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            exp_mask = (c % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (req_ready !== exp_mask) begin
                errors++;
                $display("FAIL contention_grant[%0d]: req_ready=%b, required %b", c, req_ready, exp_mask);
            end
            if (c > 0) begin
                exp_data = (c % 2 == 1) ? 32'd7 : 32'h0000_00FF;
                checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== exp_data) begin
                    errors++;
                    $display("FAIL contention_data[%0d]: valid=%b data=%h, required 1 %h",
                             c, rsp_valid, rsp_data, exp_data);
                end
            end
            model_step();
        end
    endtask

    task automatic test_backpressure();
        next_cycle();
        req_valid     = 2'b01;
        req_alu_in[0] = mk(ALU_AND, 32'h0000_F0F0, 32'h0000_FF00);
        rsp_ready     = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL bp_first_grant: req_ready=%b, required 01", req_ready);
        end
        model_step();
        next_cycle();
        rsp_ready     = 1'b0;
        req_alu_in[0] = mk(ALU_OR, 32'd1, 32'd2);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 2'b00 || rsp_valid !== 1'b1 || rsp_id !== 1'b0 ||
                rsp_data !== 32'h0000_F000 || rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall: ready=%b valid=%b id=%0d data=%h err=%b, required 00 1 0 0000f000 0",
                         req_ready, rsp_valid, rsp_id, rsp_data, rsp_err);
            end
            model_step();
        end
        next_cycle();
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL bp_drain_accept: req_ready=%b, required 01", req_ready);
        end
        model_step();
        next_cycle();
        req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd3) begin
            errors++;
            $display("FAIL bp_new_rsp: valid=%b id=%0d data=%h, required 1 0 00000003", rsp_valid, rsp_id, rsp_data);
        end
        model_step();
    endtask

    task automatic test_invalid_fun();
        next_cycle();
        req_valid     = 2'b10;
        req_alu_in[1] = mk(4'hF, 32'd1, 32'd1);
        rsp_ready     = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL invalid_grant: req_ready=%b, required 10", req_ready);
        end
        model_step();
        next_cycle();
        req_valid     = 2'b11;
        req_alu_in[0] = mk(ALU_ADD, 32'd2, 32'd2);
        req_alu_in[1] = mk(ALU_SUB, 32'd9, 32'd4);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'd0) begin
            errors++;
            $display("FAIL invalid_rsp: valid=%b id=%0d data=%h err=%b, required 1 1 00000000 1",
                     rsp_valid, rsp_id, rsp_data, rsp_err);
        end
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL invalid_ptr_advance: req_ready=%b, required 01", req_ready);
        end
        model_step();
        next_cycle();
        req_valid = 2'b10;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b10 || rsp_data !== 32'd4 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL invalid_follow: req_ready=%b data=%h err=%b, required 10 00000004 0",
                     req_ready, rsp_data, rsp_err);
        end
        model_step();
        next_cycle();
        req_valid = 2'b00;
        @(negedge clk);
        model_step();
    endtask

    task automatic test_reset_mid_op();
        next_cycle();
        req_valid     = 2'b01;
        req_alu_in[0] = mk(ALU_ADD, 32'd100, 32'd1);
        rsp_ready     = 1'b1;
        @(negedge clk);
        model_step();
        next_cycle();
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd101) begin
            errors++;
            $display("FAIL midrst_pending: valid=%b data=%h, required 1 00000065", rsp_valid, rsp_data);
        end
        model_step();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 2'b00 || rsp_data !== 32'd0) begin
            errors++;
            $display("FAIL midrst_async: valid=%b ready=%b data=%h, required 0 00 00000000",
                     rsp_valid, req_ready, rsp_data);
        end
        exp_q.delete();
        m_valid = 1'b0;
        m_ptr   = 0;
        next_cycle();
        rst_n         = 1'b1;
        req_valid     = 2'b11;
        rsp_ready     = 1'b1;
        req_alu_in[0] = mk(ALU_XOR, 32'd3, 32'd1);
        req_alu_in[1] = mk(ALU_ADD, 32'd1, 32'd1);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 2'b01) begin
            errors++;
            $display("FAIL midrst_release: valid=%b ready=%b, required 0 01", rsp_valid, req_ready);
        end
        model_step();
        next_cycle();
        req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd2) begin
            errors++;
            $display("FAIL midrst_first_rsp: valid=%b id=%0d data=%h, required 1 0 00000002",
                     rsp_valid, rsp_id, rsp_data);
        end
        model_step();
    endtask

    task automatic test_back_to_back();
        logic [NUM_REQ-1:0] exp_mask;
        logic [NUM_REQ-1:0] last_ready;
        last_ready = '0;
        for (int c = 0; c < 80; c++) begin
            next_cycle();
            for (int r = 0; r < NUM_REQ; r++) begin
                if (!(req_valid[r] && !last_ready[r])) begin
                    req_valid[r]      = ($urandom_range(0, 3) != 0);
                    req_alu_in[r].fun = 4'($urandom_range(0, 11));
                    req_alu_in[r].op1 = $urandom;
                    req_alu_in[r].op2 = $urandom;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            exp_mask = mask_of(exp_idx(req_valid, m_ptr, !m_valid || rsp_ready));
            checks++;
            if (req_ready !== exp_mask || rsp_valid !== m_valid) begin
                errors++;
                $display("FAIL b2b_cycle[%0d]: req_ready=%b rsp_valid=%b, required %b %b",
                         c, req_ready, rsp_valid, exp_mask, m_valid);
            end
            last_ready = req_ready;
            model_step();
        end
        next_cycle();
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            model_step();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_contention();
        test_backpressure();
        test_invalid_fun();
        test_reset_mid_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one combinational ALU datapath between NUM_REQ requesters, e.g. the integer issue slot and the branch/address-generation slot. A round-robin arbiter picks one request per cycle, drives the ALU, and registers the result into a single-entry response stage with valid/ready backpressure. Latency is one cycle, and throughput is one operation per cycle when the response side does not stall.

Parameters:
NUM_REQ, 2, number of requesters; legal range 2..ALU_ARB_MAX_REQ (4).
ID_W, $clog2(NUM_REQ), width of the response requester id.

Ports:
clk  input  1  the one clock; all state rises on posedge.
rst_n  input  1  reset, asynchronous and active-low.
req_valid  input  NUM_REQ  per-requester request valid.
req_alu_in  input  NUM_REQ x Bundle::AluIn  per-requester fun/op1/op2.
req_ready  output  NUM_REQ  per-requester grant; transfer occurs when valid && ready.
rsp_valid  output  1  registered result valid.
rsp_ready  input  1  consumer accepts the result.
rsp_id  output  ID_W  index of the requester that owns rsp_data.
rsp_data  output  32  ALU result.
rsp_err  output  1  the accepted fun was outside the defined ALU_* set.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
  - Round-robin pointer = 0.
  - req_ready is forced to all 0 while rst_n is low.
- Output free: out_free = !rsp_valid || rsp_ready. This is combinational, so draining and accepting can happen in the same cycle.
- Grant:
  - When out_free, req_ready is one-hot on the first valid requester found scanning ptr, ptr+1, ... mod NUM_REQ.
  - req_ready is all 0 when !out_free or no request is valid.
  - req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Requester rule: payload is held stable while valid && !ready. A requester may drop valid before grant; the arbiter tolerates this.
- Datapath: one Alu instance whose input is muxed from the granted requester. When there is no grant, the mux selects requester 0; its result is ignored.
- Accept (any grant at posedge):
  - rsp_valid<=1, rsp_id<=granted index, rsp_data<=Alu output, rsp_err<=!alu_fun_valid(fun).
  - If fun is invalid, rsp_data<=0 (never X).
- Drain without accept: rsp_valid && rsp_ready with no grant -> rsp_valid<=0. rsp_id, rsp_data and rsp_err keep their last values.
- Stall: rsp_valid && !rsp_ready -> rsp_id, rsp_data and rsp_err hold bit-stable, and no grant is issued.
- Pointer:
  - After granting index i, ptr<=(i+1) mod NUM_REQ, wrapping at NUM_REQ-1 to 0.
  - With no grant, ptr is unchanged.
- Fairness: a continuously valid requester is granted within NUM_REQ accepted transfers.
- Reset mid-operation: any in-flight result is discarded with no response emitted, and ptr returns to 0.
- No combinational path from rsp_ready to rsp_valid, rsp_id, rsp_data or rsp_err.

Decomposition:
- Package Bundle gains:
  - constant ALU_ARB_MAX_REQ=4;
  - function alu_fun_valid(fun), true exactly for the ALU_* codes;
  - typedef AluRsp {data, err}.
- The existing AluIn/AluOut types and ALU_* constants are reused unchanged.
- One sub-module, rr_arbiter (parameter N), takes req and ptr and returns a one-hot grant plus the grant index. It is purely combinational and reusable by other shared units.
- The existing Alu module is instantiated once, not duplicated.

Test Plan:
- Reset: hold rst_n=0 with req_valid=all 1 -> req_ready=0 and rsp_valid=0 throughout. On release with req_valid=2'b11, the first grant is to req 0.
- Single request: req 1 only, ADD op1=5 op2=7, rsp_ready=1 -> req_ready=2'b10 in the same cycle. Next cycle rsp_valid=1, rsp_id=1, rsp_data=12, rsp_err=0.
- Contention: both valid continuously with SUB 10-3 (req 0) and XOR 0xF0^0x0F (req 1), rsp_ready=1 -> grants alternate 0,1,0,1. rsp_data alternates 7 and 0xFF, one response per cycle.
- Backpressure: rsp_ready=0 for 3 cycles while a response is held -> req_ready=0, and rsp_id/rsp_data stay stable. Raising rsp_ready with req 0 valid drains and accepts in the same cycle, giving a new response on the next edge.
- Invalid fun: request with an undefined fun code, op1=1 op2=1 -> rsp_valid=1, rsp_err=1, rsp_data=0, and ptr advances.
- Reset mid-op: drop rst_n while rsp_valid=1 and rsp_ready=0 -> rsp_valid=0 immediately, without waiting for a clock edge. After release, ptr=0 and no stale response appears.
